// File: rtl/score_display.sv
// rtl/score_display.sv - multiplexed 4-digit common-anode 7-segment driver for an 8-bit score
module score_display #(
    parameter int SCAN_BITS = 17,
    parameter bit LZ_BLANK  = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] score,
    output logic [3:0] anode,
    output logic [7:0] digit_seg
);

    localparam logic [SCAN_BITS-1:0] PRESCALE_ONE = {{(SCAN_BITS-1){1'b0}}, 1'b1};

    logic [SCAN_BITS-1:0] prescaler;
    logic [1:0]           idx;
    logic [3:0]           anode_next;
    logic [7:0]           seg_next;

    // Active-low segment pattern {dp,g,f,e,d,c,b,a}; dp stays dark.
    function automatic logic [7:0] seg7(input logic [3:0] nibble);
        logic [7:0] pattern;
        case (nibble)
            4'h0: pattern = 8'hC0;
            4'h1: pattern = 8'hF9;
            4'h2: pattern = 8'hA4;
            4'h3: pattern = 8'hB0;
            4'h4: pattern = 8'h99;
            4'h5: pattern = 8'h92;
            4'h6: pattern = 8'h82;
            4'h7: pattern = 8'hF8;
            4'h8: pattern = 8'h80;
            4'h9: pattern = 8'h90;
            4'hA: pattern = 8'h88;
            4'hB: pattern = 8'h83;
            4'hC: pattern = 8'hC6;
            4'hD: pattern = 8'hA1;
            4'hE: pattern = 8'h86;
            4'hF: pattern = 8'h8E;
            default: pattern = 8'hFF;
        endcase
        return pattern;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            prescaler <= '0;
            idx       <= 2'd0;
            anode     <= 4'b1111;
            digit_seg <= 8'hFF;
        end else begin
            prescaler <= prescaler + PRESCALE_ONE;
            if (&prescaler) begin
                idx <= idx + 2'd1;
            end
            anode     <= anode_next;
            digit_seg <= seg_next;
        end
    end

    // Anode depends on idx alone, so an unknown score can never disturb the strobe.
    always_comb begin
        anode_next = ~(4'b0001 << idx);
        seg_next   = 8'hFF;
        case (idx)
            2'd0: seg_next = seg7(score[3:0]);
            2'd1: begin
                if (LZ_BLANK && (score[7:4] == 4'h0)) begin
                    seg_next = 8'hFF;
                end else begin
                    seg_next = seg7(score[7:4]);
                end
            end
            default: seg_next = 8'hFF;
        endcase
    end

endmodule

// File: tb/tb_score_display.sv
// tb/tb_score_display.sv - scoreboard bench for score_display with a 4-clock digit slot
module tb_score_display;

    localparam int SCAN_BITS = 2;
    localparam bit LZ_BLANK  = 1'b1;
    localparam int SLOT      = 1 << SCAN_BITS;

    typedef struct packed {
        logic [3:0] anode;
        logic [7:0] seg;
    } expect_t;

    logic       clk;
    logic       rst;
    logic [7:0] score;
    logic [3:0] anode;
    logic [7:0] digit_seg;

    expect_t    sb_q[$];
    int         vec_count;
    int         err_count;
    int         m_pre;
    int         m_idx;
    logic [7:0] seg_tab [16];

    score_display #(
        .SCAN_BITS(SCAN_BITS),
        .LZ_BLANK (LZ_BLANK)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .score    (score),
        .anode    (anode),
        .digit_seg(digit_seg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        vec_count++;
        if (got !== exp) begin
            err_count++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic expect_t model_out();
        expect_t e;
        if (rst) begin
            e.anode = 4'b1111;
            e.seg   = 8'hFF;
        end else begin
            case (m_idx)
                0: begin e.anode = 4'b1110; e.seg = seg_tab[score[3:0]]; end
                1: begin
                    e.anode = 4'b1101;
                    e.seg   = (LZ_BLANK && score[7:4] == 4'h0) ? 8'hFF : seg_tab[score[7:4]];
                end
                2: begin e.anode = 4'b1011; e.seg = 8'hFF; end
                default: begin e.anode = 4'b0111; e.seg = 8'hFF; end
            endcase
        end
        return e;
    endfunction

    // One clock: predict from the model, advance the model, then compare after the edge.
    task automatic step();
        expect_t e;
        expect_t got;
        sb_q.push_back(model_out());
        if (rst) begin
            m_pre = 0;
            m_idx = 0;
        end else begin
            if (m_pre == SLOT - 1) m_idx = (m_idx + 1) % 4;
            m_pre = (m_pre + 1) % SLOT;
        end
        @(posedge clk);
        #1;
        if (sb_q.size() == 0) begin
            check("sb_empty", 8'd0, 8'd1);
        end else begin
            e = sb_q.pop_front();
            got.anode = anode;
            got.seg   = digit_seg;
            check("anode", {4'h0, got.anode}, {4'h0, e.anode});
            check("seg", got.seg, e.seg);
            if (!rst) check("onehot", 8'($countones(~anode)), 8'd1);
        end
    endtask

    task automatic run(input logic [7:0] s, input int n);
        score = s;
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        seg_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
        vec_count = 0;
        err_count = 0;
        m_pre = 0;
        m_idx = 0;
        rst   = 1'b1;
        score = 8'h00;
        @(negedge clk);

        run(8'h00, 2);
        rst = 1'b0;
        run(8'h00, 4 * SLOT + 2);
        run(8'h12, 4 * SLOT);

        rst = 1'b1;
        run(8'h33, 1);
        rst = 1'b0;
        run(8'h33, 2);
        run(8'h87, 4 * SLOT);

        run(8'hAF, 4 * SLOT);
        run(8'h25, 4 * SLOT);

        rst = 1'b1;
        run(8'h25, 1);
        rst = 1'b0;
        run(8'h49, 2 * SLOT + 1);
        rst = 1'b1;
        run(8'h49, 1);
        rst = 1'b0;
        run(8'h49, 2 * SLOT);

        for (int i = 0; i < 60; i++) begin
            run(8'($urandom_range(0, 255)), $urandom_range(1, 3));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
        $finish;
    end

endmodule
